sp_ram_arbiter: RTL and testbench

Two-port request/grant arbiter that shares one single-port data RAM (the `sp_ram_wrap` instance) between a high-priority requester (port 0, core data side) and a low-priority requester (port 1, debug/AXI side). It multiplexes address, data, write enable and byte enable onto the RAM and returns read data with a one-cycle `rvalid` pulse to the granted master. A bounded-wait rule prevents starvation of port 1, and a saturating counter records conflict cycles for debug.

---
 rtl/sp_ram_arbiter.sv | 125 ++++++++++++
 tb/tb_sp_ram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Fixed-priority arbiter sharing one single-port data RAM between a core port (0) and a
// debug port (1), with bounded waiting for port 1 and a saturating conflict counter.
module sp_ram_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                    clk,
   input  logic                    rstn_i,

   input  logic                    m0_req_i,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic                    m0_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_be_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   output logic                    m0_gnt_o,
   output logic                    m0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,

   input  logic                    m1_req_i,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic                    m1_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_be_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   output logic                    m1_gnt_o,
   output logic                    m1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,

   output logic                    ram_en_o,
   output logic                    ram_we_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

   output logic [15:0]             conflict_cnt_o
);

   localparam int WAIT_WIDTH = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MAX_WAIT);

   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

   logic [WAIT_WIDTH-1:0] wait_q, wait_d;
   logic                  pend_q, pend_d;
   port_e                 owner_q, owner_d;
   logic [15:0]           conflict_q, conflict_d;

   // Port 1 only beats port 0 once it has been denied MAX_WAIT cycles in a row.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      m0_gnt_o = 1'b0;
      m1_gnt_o = 1'b0;
      if (rstn_i) begin
         if (m1_req_i && (!m0_req_i || wait_q == WAIT_LIMIT)) begin
            m1_gnt_o = 1'b1;
         end else if (m0_req_i) begin
            m0_gnt_o = 1'b1;
         end
      end
   end

   always_comb begin
      ram_en_o    = m0_gnt_o | m1_gnt_o;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_be_o    = '0;
      ram_wdata_o = '0;
      if (m1_gnt_o) begin
         ram_we_o    = m1_we_i;
         ram_addr_o  = m1_addr_i;
         ram_be_o    = m1_be_i;
         ram_wdata_o = m1_wdata_i;
      end else if (m0_gnt_o) begin
         ram_we_o    = m0_we_i;
         ram_addr_o  = m0_addr_i;
         ram_be_o    = m0_be_i;
         ram_wdata_o = m0_wdata_i;
      end
   end

   always_comb begin
      wait_d = '0;
      if (m1_req_i && !m1_gnt_o) begin
         wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + 1'b1;
      end

      pend_d = ram_en_o;

      owner_d = owner_q;
      if (m1_gnt_o) begin
         owner_d = PORT1;
      end else if (m0_gnt_o) begin
         owner_d = PORT0;
      end

      conflict_d = conflict_q;
      if (m0_req_i && m1_req_i && conflict_q != 16'hFFFF) begin
         conflict_d = conflict_q + 16'd1;
      end
   end

   // Clearing pend_q on reset drops any response still in flight.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         wait_q     <= '0;
         pend_q     <= 1'b0;
         owner_q    <= PORT0;
         conflict_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         wait_q     <= wait_d;
         pend_q     <= pend_d;
         owner_q    <= owner_d;
         conflict_q <= conflict_d;
      end
   end

   assign m0_rvalid_o    = pend_q && (owner_q == PORT0);
   assign m1_rvalid_o    = pend_q && (owner_q == PORT1);
   assign m0_rdata_o     = ram_rdata_i;
   assign m1_rdata_o     = ram_rdata_i;
   assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: a behavioural RAM, a byte-level reference model, a
// table of arbitration vectors, directed corner sequences and random traffic.
`timescale 1ns/1ps
module tb_sp_ram_arbiter;

   localparam int AW       = 15;
   localparam int DW       = 32;
   localparam int BW       = DW / 8;
   localparam int MAX_WAIT = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          m0_req = 1'b0, m1_req = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic          m0_we = 1'b0, m1_we = 1'b0;
   logic [BW-1:0] m0_be = '0, m1_be = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
   logic [DW-1:0] m0_rdata_o, m1_rdata_o;
   logic          ram_en_o, ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [BW-1:0] ram_be_o;
   logic [DW-1:0] ram_wdata_o;
   logic [DW-1:0] ram_rdata = '0;
   logic [15:0]   conflict_cnt_o;

   always #5 clk = ~clk;

   sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rstn_i(rstn),
      .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
      .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
      .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_be_o(ram_be_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata), .conflict_cnt_o(conflict_cnt_o)
   );

   // Single-port RAM with one cycle of read latency.
   logic [DW-1:0] ram_mem [8192];
   initial foreach (ram_mem[i]) ram_mem[i] = '0;
   always @(posedge clk) begin
      if (ram_en_o) begin
         if (ram_we_o) begin
            for (int b = 0; b < BW; b++)
               if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
         end else begin
            ram_rdata <= ram_mem[ram_addr_o[AW-1:2]];
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, 32'(act), 32'(exp));
   endtask

   // Reference model: denied-streak length, conflict total, pending response, byte memory.
   int          m_wait, m_cnt;
   bit          m_pend, m_owner, m_pend_we;
   logic [31:0] m_pend_data;
   logic [7:0]  exp_byte [int];

   function automatic logic [31:0] model_read(input logic [AW-1:0] a);
      int base = int'(a) & ~3;
      logic [31:0] w = '0;
      for (int b = 0; b < BW; b++)
         if (exp_byte.exists(base + b)) w[8*b +: 8] = exp_byte[base + b];
      return w;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_cnt = 0; m_pend = 0; m_owner = 0; m_pend_we = 0; m_pend_data = '0;
   endtask

   logic        s_gnt0, s_gnt1, s_rv0, s_rv1;
   logic [31:0] s_rdata0, s_rdata1;
   logic [15:0] s_cnt;

   // Called at a falling edge with inputs applied; checks, then advances one clock.
   task automatic cycle();
      bit g0, g1;
      logic e_we;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_be;
      logic [DW-1:0] e_wd;
      #1;
      s_gnt0 = m0_gnt_o; s_gnt1 = m1_gnt_o; s_rv0 = m0_rvalid_o; s_rv1 = m1_rvalid_o;
      s_rdata0 = m0_rdata_o; s_rdata1 = m1_rdata_o; s_cnt = conflict_cnt_o;
      g1 = m1_req && (!m0_req || m_wait == MAX_WAIT);
      g0 = m0_req && !g1;
      e_we = 1'b0; e_addr = '0; e_be = '0; e_wd = '0;
      if (g1) begin
         e_we = m1_we; e_addr = m1_addr; e_be = m1_be; e_wd = m1_wdata;
      end else if (g0) begin
         e_we = m0_we; e_addr = m0_addr; e_be = m0_be; e_wd = m0_wdata;
      end
      check1("gnt0", m0_gnt_o, g0);
      check1("gnt1", m1_gnt_o, g1);
      check1("ram_en", ram_en_o, g0 | g1);
      check1("ram_we", ram_we_o, e_we);
      check("ram_addr", 32'(ram_addr_o), 32'(e_addr));
      check("ram_be", 32'(ram_be_o), 32'(e_be));
      check("ram_wdata", ram_wdata_o, e_wd);
      check1("rvalid0", m0_rvalid_o, m_pend && !m_owner);
      check1("rvalid1", m1_rvalid_o, m_pend && m_owner);
      if (m_pend && !m_pend_we)
         check("rdata", m_owner ? m1_rdata_o : m0_rdata_o, m_pend_data);
      check("conflict_cnt", 32'(conflict_cnt_o), 32'(m_cnt));
      @(posedge clk);
      m_wait = (m1_req && !g1) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      if (m0_req && m1_req && m_cnt < 65535) m_cnt++;
      m_pend = g0 | g1;
      if (g0 | g1) begin
         m_owner   = g1;
         m_pend_we = e_we;
         if (e_we) begin
            for (int b = 0; b < BW; b++)
               if (e_be[b]) exp_byte[(int'(e_addr) & ~3) + b] = e_wd[8*b +: 8];
         end else begin
            m_pend_data = model_read(e_addr);
         end
      end
      @(negedge clk);
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
      m0_req = req; m0_we = we; m0_addr = a; m0_be = be; m0_wdata = wd;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
      m1_req = req; m1_we = we; m1_addr = a; m1_be = be; m1_wdata = wd;
   endtask

   // Grants and RAM enable must stay low while reset is held, even with requests present.
   task automatic do_reset();
      rstn = 1'b0;
      set_m0(1, 0, '0, '0, '0);
      set_m1(1, 0, '0, '0, '0);
      #1;
      check1("rst_gnt0", m0_gnt_o, 1'b0);
      check1("rst_gnt1", m1_gnt_o, 1'b0);
      check1("rst_ram_en", ram_en_o, 1'b0);
      check1("rst_rvalid0", m0_rvalid_o, 1'b0);
      check1("rst_rvalid1", m1_rvalid_o, 1'b0);
      check("rst_cnt", 32'(conflict_cnt_o), 32'd0);
      repeat (2) @(negedge clk);
      set_m0(0, 0, '0, '0, '0);
      set_m1(0, 0, '0, '0, '0);
      model_reset();
      rstn = 1'b1;
   endtask

   typedef struct {
      bit r0, r1;
      bit g0, g1;
      bit v0, v1;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #10_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 1, 0, 0, 0};
      tbl[2]  = '{1, 1, 1, 0, 1, 0};
      tbl[3]  = '{1, 1, 1, 0, 1, 0};
      tbl[4]  = '{1, 1, 1, 0, 1, 0};
      tbl[5]  = '{1, 1, 0, 1, 1, 0};
      tbl[6]  = '{0, 1, 0, 1, 0, 1};
      tbl[7]  = '{1, 0, 1, 0, 0, 1};
      tbl[8]  = '{0, 0, 0, 0, 1, 0};
      tbl[9]  = '{0, 0, 0, 0, 0, 0};
      tbl[10] = '{0, 1, 0, 1, 0, 0};
      tbl[11] = '{1, 1, 1, 0, 0, 1};
      tbl[12] = '{0, 1, 0, 1, 1, 0};
      model_reset();

      @(negedge clk);
      do_reset();

      // Arbitration table from a fresh reset.
      for (int i = 0; i < 13; i++) begin
         set_m0(tbl[i].r0, 0, 15'h0100, 4'hF, '0);
         set_m1(tbl[i].r1, 0, 15'h0200, 4'hF, '0);
         cycle();
         check1("tbl_gnt0", s_gnt0, tbl[i].g0);
         check1("tbl_gnt1", s_gnt1, tbl[i].g1);
         check1("tbl_rv0", s_rv0, tbl[i].v0);
         check1("tbl_rv1", s_rv1, tbl[i].v1);
      end

      // Port 0 alone: write then read back.
      do_reset();
      set_m0(1, 1, 15'h0040, 4'hF, 32'hDEADBEEF);
      cycle();
      check1("p0_wr_gnt", s_gnt0, 1'b1);
      check1("p0_wr_gnt1", s_gnt1, 1'b0);
      set_m0(1, 0, 15'h0040, 4'hF, '0);
      cycle();
      check1("p0_rd_gnt", s_gnt0, 1'b1);
      check1("p0_wr_rv", s_rv0, 1'b1);
      check1("p0_rv1", s_rv1 | s_gnt1, 1'b0);
      set_m0(0, 0, '0, '0, '0);
      cycle();
      check1("p0_rd_rv", s_rv0, 1'b1);
      check("p0_rd_data", s_rdata0, 32'hDEADBEEF);
      check1("p0_rv1b", s_rv1, 1'b0);

      // Continuous dual request for 20 cycles.
      do_reset();
      set_m0(1, 0, 15'h0010, 4'hF, '0);
      set_m1(1, 0, 15'h0020, 4'hF, '0);
      for (int c = 0; c < 20; c++) begin
         cycle();
         check1("dual_gnt1", s_gnt1, (c % 5) == 4);
         check1("dual_gnt0", s_gnt0, (c % 5) != 4);
      end
      set_m0(0, 0, '0, '0, '0);
      set_m1(0, 0, '0, '0, '0);
      cycle();
      check("dual_cnt", 32'(s_cnt), 32'd20);

      // Back-to-back port 1 reads.
      for (int i = 0; i < 3; i++) begin
         set_m0(1, 1, 15'(4 * i), 4'hF, 32'hA000 + 32'(4 * i));
         cycle();
      end
      set_m0(0, 0, '0, '0, '0);
      for (int i = 0; i < 4; i++) begin
         if (i < 3) set_m1(1, 0, 15'(4 * i), 4'hF, '0);
         else set_m1(0, 0, '0, '0, '0);
         cycle();
         if (i < 3) check1("b2b_gnt1", s_gnt1, 1'b1);
         if (i > 0) begin
            check1("b2b_rv1", s_rv1, 1'b1);
            check("b2b_data", s_rdata1, 32'hA000 + 32'(4 * (i - 1)));
         end
      end

      // Byte-lane write over an existing word.
      set_m0(1, 1, 15'h0080, 4'hF, 32'h11223344);
      cycle();
      set_m0(1, 1, 15'h0080, 4'h2, 32'h0000AB00);
      cycle();
      set_m0(1, 0, 15'h0080, 4'hF, '0);
      cycle();
      set_m0(0, 0, '0, '0, '0);
      cycle();
      check1("byte_rv0", s_rv0, 1'b1);
      check("byte_data", s_rdata0, 32'h1122AB44);

      // Reset asserted in the cycle after a port 1 read grant.
      do_reset();
      set_m1(1, 0, 15'h0004, 4'hF, '0);
      #1;
      check1("mid_gnt1", m1_gnt_o, 1'b1);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      set_m1(0, 0, '0, '0, '0);
      @(negedge clk);
      #1;
      check1("mid_rv1_a", m1_rvalid_o, 1'b0);
      @(negedge clk);
      #1;
      check1("mid_rv1_b", m1_rvalid_o, 1'b0);
      @(negedge clk);
      model_reset();
      rstn = 1'b1;
      cycle();
      check1("mid_rv1_c", s_rv1, 1'b0);
      check("mid_cnt", 32'(s_cnt), 32'd0);
      set_m0(1, 0, 15'h0100, 4'hF, '0);
      set_m1(1, 0, 15'h0008, 4'hF, '0);
      cycle();
      check1("mid_wait0", s_gnt0, 1'b1);
      set_m0(0, 0, '0, '0, '0);
      cycle();
      check1("mid_first_gnt1", s_gnt1, 1'b1);
      set_m1(0, 0, '0, '0, '0);
      cycle();
      check1("mid_first_rv1", s_rv1, 1'b1);
      check("mid_first_data", s_rdata1, 32'hA008);

      // Random traffic; a denied port holds its request and fields.
      do_reset();
      s_gnt0 = 1'b0;
      s_gnt1 = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!m0_req || s_gnt0)
            set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 15'({$urandom_range(0, 31), 2'b00}),
                   4'($urandom), $urandom);
         if (!m1_req || s_gnt1)
            set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 15'({$urandom_range(0, 31), 2'b00}),
                   4'($urandom), $urandom);
         cycle();
      end

      // Conflict counter saturation.
      do_reset();
      set_m0(1, 0, 15'h0010, 4'hF, '0);
      set_m1(1, 0, 15'h0020, 4'hF, '0);
      repeat (70000) cycle();
      set_m0(0, 0, '0, '0, '0);
      set_m1(0, 0, '0, '0, '0);
      cycle();
      check("sat_cnt", 32'(s_cnt), 32'h0000FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
